// File: rtl/data_buffer_mw_pkg.sv
// Shared definitions for the multi-width endpoint data buffer: data_size
// encodings and the access-size helper.
package data_buffer_mw_pkg;

    localparam logic [1:0] DS_BYTE     = 2'd0;
    localparam logic [1:0] DS_HALF     = 2'd1;
    localparam logic [1:0] DS_WORD     = 2'd2;
    localparam logic [1:0] DS_WORD_ALT = 2'd3;

    // Number of bytes moved by one AHB-side access of the given encoding.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] data_size,
                                                 input int unsigned word_bytes);
        logic [2:0] n;
        case (data_size)
            DS_BYTE:     n = 3'd1;
            DS_HALF:     n = 3'd2;
            DS_WORD:     n = 3'(word_bytes);
            DS_WORD_ALT: n = 3'(word_bytes);
            default:     n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/data_buffer_mw_ram.sv
// DEPTH x 8 byte store with a WORD_BYTES-wide masked write port and a
// WORD_BYTES-wide combinational read port; both wrap at DEPTH.
module db_byte_ram #(
    parameter int DEPTH      = 64,
    parameter int WORD_BYTES = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [WORD_BYTES-1:0]   wr_be_i,
    input  logic [8*WORD_BYTES-1:0] wr_data_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [8*WORD_BYTES-1:0] rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    // Byte k lands at base+k; AW-bit address arithmetic gives the wrap for free.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (wr_be_i[k]) begin
                mem_q[wr_addr_i + AW'(k)] <= wr_data_i[8*k +: 8];
            end
        end
    end

    // Little-endian lookahead of WORD_BYTES bytes starting at the read base.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_data_o[8*k +: 8] = mem_q[rd_addr_i + AW'(k)];
        end
    end

endmodule

// File: rtl/data_buffer_mw.sv
// USB/AHB endpoint byte FIFO with 1/2/WORD_BYTES AHB accesses, all-or-nothing
// rejection and lock arbitration. Define DATA_BUFFER_MW_ERR_FLAGS_EN for sticky
// overflow/underflow flags; otherwise those outputs are tied low.
module data_buffer_mw
    import data_buffer_mw_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WORD_BYTES = 4,
    parameter int OCC_W      = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    lock_db,
    output logic                    lock_error,
    input  logic                    store_rx_packet_data,
    input  logic [7:0]              rx_packet_data,
    input  logic                    get_tx_packet_data,
    output logic [7:0]              tx_packet_data,
    input  logic                    store_tx_data,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic                    get_rx_data,
    output logic [8*WORD_BYTES-1:0] rx_data,
    input  logic [1:0]              data_size,
    output logic [OCC_W-1:0]        buffer_occupancy,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [OCC_W-1:0]        wp_q, wp_d;
    logic [OCC_W-1:0]        rp_q, rp_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    lock_error_q, lock_error_d;

    logic [2:0]              n_s;
    logic [OCC_W-1:0]        n_occ_s;
    logic [OCC_W-1:0]        space_s;
    logic                    push_tx_s, pop_rx_s;
    logic [OCC_W-1:0]        push_len_s, pop_len_s;
    logic                    ovf_evt_s, unf_evt_s;
    logic [WORD_BYTES-1:0]   wr_be_s;
    logic [8*WORD_BYTES-1:0] wr_data_s;
    logic [8*WORD_BYTES-1:0] rd_data_s;

    assign n_s       = size_to_bytes(data_size, WORD_BYTES);
    assign n_occ_s   = OCC_W'(n_s);
    assign space_s   = OCC_W'(DEPTH) - occ_q;
    assign push_tx_s = store_tx_data & ~lock_db;
    assign pop_rx_s  = get_rx_data & ~lock_db;

    // Push arbitration: AHB beats USB; a push that does not fit is dropped whole.
    always_comb begin
        push_len_s = '0;
        wr_data_s  = '0;
        ovf_evt_s  = 1'b0;
        if (push_tx_s) begin
            push_len_s = n_occ_s;
            wr_data_s  = tx_data;
            ovf_evt_s  = store_rx_packet_data;
        end else if (store_rx_packet_data) begin
            push_len_s = OCC_W'(1);
            wr_data_s  = {{(8*WORD_BYTES-8){1'b0}}, rx_packet_data};
        end else begin
            push_len_s = '0;
        end
        if (push_len_s > space_s) begin
            push_len_s = '0;
            ovf_evt_s  = 1'b1;
        end else begin
            push_len_s = push_len_s;
        end
    end

    // Pop arbitration: AHB beats USB; checked against occupancy before any push.
    always_comb begin
        pop_len_s = '0;
        unf_evt_s = 1'b0;
        if (pop_rx_s) begin
            pop_len_s = n_occ_s;
            unf_evt_s = get_tx_packet_data;
        end else if (get_tx_packet_data) begin
            pop_len_s = OCC_W'(1);
        end else begin
            pop_len_s = '0;
        end
        if (pop_len_s > occ_q) begin
            pop_len_s = '0;
            unf_evt_s = 1'b1;
        end else begin
            pop_len_s = pop_len_s;
        end
    end

    // Byte enables for the accepted push; suppressed while resetting or flushing.
    always_comb begin
        wr_be_s = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (OCC_W'(k) < push_len_s && !rst && !clear) begin
                wr_be_s[k] = 1'b1;
            end else begin
                wr_be_s[k] = 1'b0;
            end
        end
    end

    // Pointer, occupancy and lock-error next state.
    always_comb begin
        wp_d         = wp_q + push_len_s;
        rp_d         = rp_q + pop_len_s;
        occ_d        = occ_q + push_len_s - pop_len_s;
        lock_error_d = lock_db & (store_tx_data | get_rx_data);
    end

    // State registers: rst and clear both flush, only rst drops the lock pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            rp_q         <= '0;
            occ_q        <= '0;
            lock_error_q <= 1'b0;
        end else if (clear) begin
            wp_q         <= '0;
            rp_q         <= '0;
            occ_q        <= '0;
            lock_error_q <= lock_error_d;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            occ_q        <= occ_d;
            lock_error_q <= lock_error_d;
        end
    end

`ifdef DATA_BUFFER_MW_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags; a flush keeps them and a discarded access raises nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q  <= overflow_q;
            underflow_q <= underflow_q;
        end else begin
            overflow_q  <= overflow_q | ovf_evt_s;
            underflow_q <= underflow_q | unf_evt_s;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_evt_s;
    assign unused_evt_s = ovf_evt_s ^ unf_evt_s;
    assign overflow     = 1'b0;
    assign underflow    = 1'b0;
`endif

    db_byte_ram #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_ram (
        .clk_i     (clk),
        .wr_addr_i (wp_q[AW-1:0]),
        .wr_be_i   (wr_be_s),
        .wr_data_i (wr_data_s),
        .rd_addr_i (rp_q[AW-1:0]),
        .rd_data_o (rd_data_s)
    );

    // Lookahead shows only bytes both requested and actually held.
    always_comb begin
        rx_data = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (OCC_W'(k) < n_occ_s && OCC_W'(k) < occ_q) begin
                rx_data[8*k +: 8] = rd_data_s[8*k +: 8];
            end else begin
                rx_data[8*k +: 8] = 8'h00;
            end
        end
    end

    assign tx_packet_data   = (occ_q == '0) ? 8'h00 : rd_data_s[7:0];
    assign full             = (occ_q == OCC_W'(DEPTH));
    assign empty            = (occ_q == '0);
    assign buffer_occupancy = occ_q;
    assign lock_error       = lock_error_q;

endmodule

// File: tb/tb_data_buffer_mw.sv
// Self-checking bench for data_buffer_mw: directed scenarios plus randomized
// traffic against a queue-based model of the byte FIFO.
module tb_data_buffer_mw;

    localparam int DEPTH = 64;
    localparam int WB    = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;
`ifdef DATA_BUFFER_MW_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, clear, lock_db, lock_error;
    logic            store_rx_packet_data, get_tx_packet_data;
    logic [7:0]      rx_packet_data, tx_packet_data;
    logic            store_tx_data, get_rx_data;
    logic [8*WB-1:0] tx_data, rx_data;
    logic [1:0]      data_size;
    logic [OCC_W-1:0] buffer_occupancy;
    logic            full, empty, overflow, underflow;

    always #5 clk = ~clk;

    data_buffer_mw #(.DEPTH(DEPTH), .WORD_BYTES(WB)) dut (
        .clk(clk), .rst(rst), .clear(clear), .lock_db(lock_db), .lock_error(lock_error),
        .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data),
        .get_tx_packet_data(get_tx_packet_data), .tx_packet_data(tx_packet_data),
        .store_tx_data(store_tx_data), .tx_data(tx_data),
        .get_rx_data(get_rx_data), .rx_data(rx_data), .data_size(data_size),
        .buffer_occupancy(buffer_occupancy), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    byte unsigned mq[$];
    bit m_ovf, m_unf, m_lerr;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int sz(input logic [1:0] ds);
        return (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : WB;
    endfunction

    task automatic set_idle();
        rst = 1'b0; clear = 1'b0; lock_db = 1'b0;
        store_rx_packet_data = 1'b0; rx_packet_data = 8'h00;
        get_tx_packet_data = 1'b0; store_tx_data = 1'b0; tx_data = '0;
        get_rx_data = 1'b0; data_size = 2'd0;
    endtask

    // Queue model of one clock edge, driven by the inputs currently applied.
    task automatic model_update();
        int pre, n, npop;
        bit ov, un;
        if (rst) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_lerr = 1'b0;
            return;
        end
        m_lerr = lock_db && (store_tx_data || get_rx_data);
        if (clear) begin
            mq.delete();
            return;
        end
        pre = mq.size(); n = sz(data_size); npop = 0; ov = 1'b0; un = 1'b0;
        if (store_tx_data && !lock_db) begin
            if (store_rx_packet_data) ov = 1'b1;
            if (pre + n <= DEPTH) begin
                for (int k = 0; k < n; k++) mq.push_back(tx_data[8*k +: 8]);
            end else ov = 1'b1;
        end else if (store_rx_packet_data) begin
            if (pre < DEPTH) mq.push_back(rx_packet_data);
            else ov = 1'b1;
        end
        if (get_rx_data && !lock_db) begin
            if (get_tx_packet_data) un = 1'b1;
            if (n <= pre) npop = n; else un = 1'b1;
        end else if (get_tx_packet_data) begin
            if (pre >= 1) npop = 1; else un = 1'b1;
        end
        for (int k = 0; k < npop; k++) void'(mq.pop_front());
        if (ov && FLAGS_EN) m_ovf = 1'b1;
        if (un && FLAGS_EN) m_unf = 1'b1;
    endtask

    task automatic compare_all();
        logic [31:0] erx;
        int n;
        n = sz(data_size);
        erx = '0;
        for (int k = 0; k < n && k < mq.size(); k++) erx[8*k +: 8] = mq[k];
        chk("occupancy", 32'(buffer_occupancy), mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("tx_packet_data", tx_packet_data, (mq.size() != 0) ? mq[0] : 8'h00);
        chk("rx_data", rx_data, erx);
        chk("lock_error", lock_error, m_lerr);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int phase, p_push, p_pop;
        set_idle();
        rst = 1'b1; step(); step(); set_idle();
        chk("rst_occ", 32'(buffer_occupancy), 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);

        // Single USB byte in and out.
        store_rx_packet_data = 1'b1; rx_packet_data = 8'hD9; step(); set_idle();
        chk("t1_occ", 32'(buffer_occupancy), 1);
        chk("t1_head", tx_packet_data, 8'hD9);
        chk("t1_model_len", mq.size(), 1);
        get_tx_packet_data = 1'b1; step(); set_idle();
        chk("t1_pop_occ", 32'(buffer_occupancy), 0);
        chk("t1_pop_empty", empty, 1);

        // Fill to capacity, then one more.
        for (int i = 0; i < DEPTH; i++) begin
            store_rx_packet_data = 1'b1; rx_packet_data = 8'(i); step();
        end
        set_idle();
        chk("t2_full", full, 1);
        chk("t2_occ", 32'(buffer_occupancy), 64);
        store_rx_packet_data = 1'b1; rx_packet_data = 8'hEE; step(); set_idle();
        chk("t2_occ_after", 32'(buffer_occupancy), 64);
        chk("t2_ovf", overflow, FLAGS_EN);

        // Flush keeps the error flag, then a word push drained byte-wise.
        clear = 1'b1; step(); set_idle();
        chk("clr_occ", 32'(buffer_occupancy), 0);
        chk("clr_ovf_kept", overflow, FLAGS_EN);
        store_tx_data = 1'b1; tx_data = 32'h44332211; data_size = 2'd2; step(); set_idle();
        chk("t3_occ", 32'(buffer_occupancy), 4);
        for (int i = 0; i < 4; i++) begin
            get_tx_packet_data = 1'b1; #1;
            chk("t3_byte", tx_packet_data, 8'((i + 1) * 17));
            step(); set_idle();
        end
        chk("t3_empty", empty, 1);

        // Word access straddling the wrap.
        rst = 1'b1; step(); set_idle();
        for (int i = 0; i < 62; i++) begin
            store_rx_packet_data = 1'b1; rx_packet_data = 8'(i + 100); step();
        end
        set_idle();
        for (int i = 0; i < 62; i++) begin
            get_tx_packet_data = 1'b1; step();
        end
        set_idle();
        store_tx_data = 1'b1; tx_data = 32'hAABBCCDD; data_size = 2'd2; step(); set_idle();
        chk("t4_occ", 32'(buffer_occupancy), 4);
        get_rx_data = 1'b1; data_size = 2'd2; #1;
        chk("t4_rx_data", rx_data, 32'hAABBCCDD);
        step(); set_idle();
        chk("t4_occ_after", 32'(buffer_occupancy), 0);

        // Rejected oversize pop, then a half-word pop.
        rst = 1'b1; step(); set_idle();
        for (int i = 0; i < 3; i++) begin
            store_rx_packet_data = 1'b1; rx_packet_data = 8'(8'hB0 + i); step();
        end
        set_idle();
        get_rx_data = 1'b1; data_size = 2'd2; step(); set_idle();
        chk("t5_occ", 32'(buffer_occupancy), 3);
        chk("t5_unf", underflow, FLAGS_EN);
        get_rx_data = 1'b1; data_size = 2'd1; #1;
        chk("t5_rx_data", rx_data, 32'h0000B1B0);
        step(); set_idle();
        chk("t5_occ_after", 32'(buffer_occupancy), 1);

        // Locked AHB push, then clear racing a push.
        lock_db = 1'b1; store_tx_data = 1'b1; tx_data = 32'h12345678; step(); set_idle();
        chk("t6_occ", 32'(buffer_occupancy), 1);
        chk("t6_lock_err", lock_error, 1);
        step();
        chk("t6_lock_err_drop", lock_error, 0);
        clear = 1'b1; store_rx_packet_data = 1'b1; rx_packet_data = 8'h55; step(); set_idle();
        chk("t6_clear_occ", 32'(buffer_occupancy), 0);

        // Randomized traffic alternating fill, drain and mixed phases.
        rst = 1'b1; step(); set_idle();
        for (int c = 0; c < 4000; c++) begin
            phase  = (c / 150) % 3;
            p_push = (phase == 0) ? 75 : (phase == 1) ? 15 : 45;
            p_pop  = (phase == 0) ? 15 : (phase == 1) ? 75 : 45;
            rst     = ($urandom_range(0, 599) == 0);
            clear   = ($urandom_range(0, 99) == 0);
            lock_db = ($urandom_range(0, 5) == 0);
            store_rx_packet_data = ($urandom_range(0, 99) < p_push);
            store_tx_data        = ($urandom_range(0, 99) < p_push / 2);
            get_tx_packet_data   = ($urandom_range(0, 99) < p_pop);
            get_rx_data          = ($urandom_range(0, 99) < p_pop / 2);
            rx_packet_data = 8'($urandom);
            tx_data        = 32'($urandom);
            data_size      = 2'($urandom_range(0, 3));
            step();
        end
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
